dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
// - Data-memory responder: the memory end of the CPU datapath's load/store request interface.
// - Holds a word-organised RAM and answers each read or write after a programmable wait.
// - Signals completion with a one-cycle ready pulse, and a fault on illegal requests.
// - Sits between the datapath and the system bus/top level; single requester, one outstanding op.
// PARAMETERS
// - WORDS    1024  number of 32-bit words; power of two, >= 4
// - LATENCY  2     extra wait cycles before the response (0..15)
// PORTS
// - clk          in   1   clock, all state updates on rising edge
// - rst          in   1   reset, synchronous, active-high
// - dmem_ren     in   1   read request; held until dmem_ready
// - dmem_wen     in   1   write request; held until dmem_ready
// - dmem_addr    in   32  byte address; bits [1:0] ignored, word index = addr[$clog2(WORDS)+1:2]
// - dmem_store   in   32  write data, byte lanes already positioned by requester
// - dmem_strobe  in   4   byte-lane write enables (writes only)
// - dmem_load    out  32  read data, valid only while dmem_ready=1 and dmem_fault=0
// - dmem_ready   out  1   one-cycle completion pulse
// - dmem_fault   out  1   qualifies dmem_ready: request rejected, no memory side effect
// BEHAVIOUR
// - Reset: state=IDLE, wait counter=0, dmem_ready=0, dmem_fault=0, dmem_load=0.
// - Reset does not clear the RAM array.
// - FSM states: IDLE, WAIT, RESP.
//   - IDLE: accept a request when dmem_ren|dmem_wen is sampled high.
//     - On accept, capture addr/data/strobe/kind into registers.
//     - Go to WAIT with counter=LATENCY, or directly to RESP if LATENCY=0.
//   - WAIT: decrement the counter; go to RESP when it reaches 1.
//   - RESP: drive dmem_ready=1 for exactly one cycle, then return to IDLE.
// - Latency: request sampled at edge t -> dmem_ready high during cycle t+1+LATENCY.
// - Write commit:
//   - Occurs on the edge that ends the RESP cycle.
//   - Only lanes with strobe=1 change.
//   - Read-after-write to the same word returns the new data.
// - Read data: registered from the RAM; dmem_load holds its last value outside ready; X never driven.
// - Fault, decided at accept time; still takes full latency, then ready=1 with fault=1:
//   - dmem_ren and dmem_wen both high;
//   - byte address >= WORDS*4;
//   - write with strobe not in {0001,0010,0100,1000,0011,1100,1111}.
//   - Faulted writes never modify the RAM; dmem_load=0 on a faulted read.
// - Abort: if both ren and wen drop while in WAIT, return to IDLE next cycle.
//   - No ready pulse, no write.
// - Back-to-back: a request still high in the cycle after RESP is accepted as a new request.
//   - Minimum spacing = 2+LATENCY cycles per op.
// - Reset mid-operation: abort immediately; a pending write is discarded.
// - Request inputs are ignored in WAIT/RESP (captured copies are used).
// CONFIGURATION
// - DMEM_PERF_EN defined:
//   - adds outputs perf_reads[31:0], perf_writes[31:0], perf_faults[31:0];
//   - each increments once per dmem_ready of that class (faults counted only in perf_faults);
//   - all cleared by rst; wrap at 2^32.
// - DMEM_PERF_EN undefined: ports and counters absent, behaviour otherwise identical.
// TESTING
// - LATENCY=2: write 0xDEADBEEF @0x10 strobe 1111, then read @0x10 -> ready 3 cycles after each accept, load=0xDEADBEEF.
// - Byte write 0xAA via strobe 0100 @0x10 over 0xDEADBEEF -> subsequent read 0xDEAABEEF.
// - Read @WORDS*4 -> ready with fault=1, load=0; write strobe 0101 -> fault, RAM word unchanged.
// - ren and wen both high -> fault; drop ren in WAIT -> no ready, FSM back to IDLE, next request served normally.
// - rst asserted in WAIT of a write @0x20 -> ready stays 0, word @0x20 keeps old value, outputs at reset values.
// - DMEM_PERF_EN: 3 reads, 2 writes, 1 fault -> perf_reads=3, perf_writes=2, perf_faults=1; rst -> all 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-organised data RAM answering one load/store at a time after LATENCY wait cycles, then a one-cycle ready (optionally faulted).
// Requester holds ren/wen until ready; dropping both during WAIT aborts the op. `DMEM_PERF_EN adds perf_reads/perf_writes/perf_faults.
module dmem_responder #(
    parameter int WORDS   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_ren,
    input  logic        dmem_wen,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_store,
    input  logic [3:0]  dmem_strobe,
    output logic [31:0] dmem_load,
    output logic        dmem_ready,
    output logic        dmem_fault
`ifdef DMEM_PERF_EN
    ,
    output logic [31:0] perf_reads,
    output logic [31:0] perf_writes,
    output logic [31:0] perf_faults
`endif
);

    localparam int AW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state, state_nxt;
    logic [3:0]     cnt, cnt_nxt;
    logic [AW-1:0]  idx_q;
    logic [31:0]    data_q;
    logic [3:0]     strb_q;
    logic           wr_q, flt_q;
    logic [31:0]    mem [WORDS];

    logic           req, accept, strb_ok, addr_oob, req_fault;
    logic [AW-1:0]  rd_idx;
    logic           rd_wr, rd_flt;
    logic           unused_addr;

    assign unused_addr = ^dmem_addr[1:0];
    assign req         = dmem_ren | dmem_wen;
    assign addr_oob    = (dmem_addr >> (AW + 2)) != 32'd0;

    always_comb begin
        strb_ok = 1'b0;
        case (dmem_strobe)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: strb_ok = 1'b1;
            default:                   strb_ok = 1'b0;
        endcase
    end

    assign req_fault = (dmem_ren & dmem_wen) | addr_oob | (dmem_wen & ~strb_ok);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt <= 4'd1) begin
                    state_nxt = RESP;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero latency the RESP data must come straight from the request inputs.
    assign rd_idx = accept ? dmem_addr[AW+1:2] : idx_q;
    assign rd_wr  = accept ? dmem_wen          : wr_q;
    assign rd_flt = accept ? req_fault         : flt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            idx_q     <= '0;
            data_q    <= 32'd0;
            strb_q    <= 4'd0;
            wr_q      <= 1'b0;
            flt_q     <= 1'b0;
            dmem_load <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                idx_q  <= dmem_addr[AW+1:2];
                data_q <= dmem_store;
                strb_q <= dmem_strobe;
                wr_q   <= dmem_wen;
                flt_q  <= req_fault;
            end
            if (state_nxt == RESP && state != RESP) begin
                if (rd_flt)
                    dmem_load <= 32'd0;
                else if (!rd_wr)
                    dmem_load <= mem[rd_idx];
            end
        end
    end

    // RAM has no reset; the write lands on the edge that closes the RESP cycle.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && wr_q && !flt_q) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i])
                    mem[idx_q][8*i +: 8] <= data_q[8*i +: 8];
            end
        end
    end

    assign dmem_ready = (state == RESP);
    assign dmem_fault = (state == RESP) & flt_q;

`ifdef DMEM_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_reads  <= 32'd0;
            perf_writes <= 32'd0;
            perf_faults <= 32'd0;
        end else if (dmem_ready) begin
            if (flt_q)
                perf_faults <= perf_faults + 32'd1;
            else if (wr_q)
                perf_writes <= perf_writes + 32'd1;
            else
                perf_reads <= perf_reads + 32'd1;
        end
    end
`endif

endmodule
